// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, defaults and parity constants
// shared by the UART receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_uart_if.sv
// rx_uart_if: received-word valid/ready bundle
// between the UART receiver and its data sink.
interface rx_uart_if #(
  parameter int W = 9
);

  logic [W-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         o_parity_err;
  logic         o_framing_err;

  modport master (
    output o_data,
    output o_valid,
    output o_parity_err,
    output o_framing_err,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_parity_err,
    input  o_framing_err,
    output i_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the serial line,
// resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// rx_uart: UART receiver, start/data/parity/stop, LSB first.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 voting around mid-bit.
module rx_uart
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = PAR_EVEN,
  parameter int OVERSAMPLE       = OVERSAMPLE_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sample_tick,
  input  logic      serial_in,
  rx_uart_if.master rx,
  output logic      o_overrun,
  output logic      o_busy
);

  localparam int DW = INPUT_DATA_WIDTH;
  localparam int OW = DW + PARITY_ENABLED;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DW + 1);

  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  logic          rx_s;
  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] shreg;
  logic          par_q;
  logic          bit_val;
  logic          dec;
  logic          last_bit;
  logic          shift_en;
  logic          par_en;
  logic          commit;
  logic [OW-1:0] word;
  logic          perr;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] MID_LO = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] DEC    = CW'(OVERSAMPLE / 2);

  logic v_lo;
  logic v_mid;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_lo  <= 1'b1;
      v_mid <= 1'b1;
    end else if (sample_tick) begin
      if (cnt == MID_LO) v_lo  <= rx_s;
      if (cnt == MID)    v_mid <= rx_s;
    end
  end

  assign bit_val = maj3(v_lo, v_mid, rx_s);
  assign dec     = sample_tick && (cnt == DEC);
`else
  assign bit_val = rx_s;
  assign dec     = sample_tick && (cnt == MID);
`endif

  assign last_bit = (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (sample_tick && !rx_s)
          state_nxt = ST_START;
      ST_START:
        if (dec)
          state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (dec && last_bit)
          state_nxt = (PARITY_ENABLED != 0) ?
                      ST_PARITY : ST_STOP;
      ST_PARITY:
        if (dec)
          state_nxt = ST_STOP;
      ST_STOP:
        if (dec)
          state_nxt = bit_val ? ST_IDLE : ST_BREAK;
      ST_BREAK:
        if (rx_s)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != ST_IDLE);
    shift_en = (state == ST_DATA) && dec;
    par_en   = (state == ST_PARITY) && dec;
    commit   = (state == ST_STOP) && dec;
  end

  // cnt holds the phase index of the next tick; the
  // detecting tick is phase 0 of the start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par_q <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (sample_tick) cnt <= CW'(1);
      end else if (sample_tick) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      if (state == ST_START) idx <= '0;
      if (shift_en) begin
        shreg <= DW'({bit_val, shreg} >> 1);
        idx   <= idx + 1'b1;
      end
      if (par_en) par_q <= bit_val;
    end
  end

  assign word = OW'({par_q, shreg});
  assign perr = (PARITY_ENABLED != 0) &&
                ((^shreg ^ par_q) != PARITY_ODD[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx.o_data        <= '0;
      rx.o_valid       <= 1'b0;
      rx.o_parity_err  <= 1'b0;
      rx.o_framing_err <= 1'b0;
      o_overrun        <= 1'b0;
    end else begin
      o_overrun <= commit && rx.o_valid && !rx.i_ready;
      if (commit) begin
        rx.o_data        <= word;
        rx.o_valid       <= 1'b1;
        rx.o_parity_err  <= perr;
        rx.o_framing_err <= ~bit_val;
      end else if (rx.o_valid && rx.i_ready) begin
        rx.o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rx_uart.md
# rx_uart

Serial receiver that consumes the UART line driven by the transmitter. It deserialises start + data + optional parity + stop frames, LSB first, using an oversampling tick. Each word is presented as `{parity_bit, data}`, the same format the transmitter accepts, so a loopback returns words unchanged. Sits between the pad/serial input and the downstream data sink.

## Interface
- `INPUT_DATA_WIDTH`, 8: data bits per frame.
- `PARITY_ENABLED`, 1: 1 = parity bit present and checked; 0 = none.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit period; even, ≥8.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-`clk` pulse, OVERSAMPLE per bit period.
- `serial_in`  in  1  asynchronous serial line, idle high.
- `i_ready`  in  1  sink accepts `o_data` when high with `o_valid`.
- `o_data`  out  INPUT_DATA_WIDTH+PARITY_ENABLED  `{parity_bit, data}` as received.
- `o_valid`  out  1  word available; held until `i_ready`.
- `o_parity_err`  out  1  parity mismatch on current word; qualified by `o_valid`.
- `o_framing_err`  out  1  stop bit sampled low on current word; qualified by `o_valid`.
- `o_overrun`  out  1  one-`clk` pulse when an unaccepted word is overwritten.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values:
  - `o_data` = 0; `o_valid`, all error flags, `o_overrun` and `o_busy` = 0.
  - State = IDLE; synchroniser flops = 1.
  - Reset mid-frame abandons the frame with no output.
- `serial_in` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Bit counters advance only on `sample_tick`. `MID` = OVERSAMPLE/2−1.
- States:
  - **IDLE:** on `sample_tick` with `rx_s`=0 → START, tick counter cleared.
  - **START:** at tick MID, sample `rx_s`.
    - Sample 1 (glitch) → IDLE.
    - Sample 0 → DATA, counter cleared, bit index 0.
  - **DATA:** every OVERSAMPLE ticks, at tick MID, sample and store into bit[index], LSB first.
    - After INPUT_DATA_WIDTH bits → PARITY if PARITY_ENABLED, else → STOP.
  - **PARITY:** sample at tick MID → STOP.
  - **STOP:** sample at tick MID, then commit the word.
    - Stop = 1 → IDLE.
    - Stop = 0 → BREAK.
  - **BREAK:** wait until `rx_s`=1 → IDLE. No start detection while in BREAK.
- Commit:
  - `o_data`, `o_parity_err` and `o_framing_err` load together; `o_valid` is set.
  - `o_parity_err` = XOR(data, parity) ≠ PARITY_ODD. It is always 0 when PARITY_ENABLED=0.
  - If `o_valid` is already high and not being accepted in that cycle: `o_overrun` pulses and the new word replaces the old one.
- Handshake: `o_valid` clears on the cycle after `o_valid && i_ready`, unless a commit happens in the same cycle. Commit wins and `o_valid` stays 1.
- Returning to IDLE at mid-stop-bit permits back-to-back frames with no idle gap.

## Timing
- Synchroniser adds 2 `clk` of latency.
- A word commits one `clk` after the `sample_tick` that samples the stop bit.
  - Nominal: ≈(1 + INPUT_DATA_WIDTH + PARITY_ENABLED + 0.5) bit periods after the falling edge.
- `o_valid` rises the `clk` after the stop sample. Minimum high time is 1 `clk`.
- `o_overrun` lasts exactly 1 `clk`, coincident with the commit that overwrote the word.
- `sample_tick` outside BUSY states has no effect except IDLE start detection.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined:
  - Each bit value is the 2-of-3 majority of `rx_s` at ticks MID−1, MID, MID+1.
  - Decision, state advance and commit occur at tick MID+1.
  - The start check also uses the vote.
- Not defined: single sample at tick MID. No vote registers are present.

## Structure
- Shared package `uart_pkg`:
  - State encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Default OVERSAMPLE.
  - Parity-type constants (EVEN=0, ODD=1), shared with the transmit side.
- Sub-module `uart_rx_sync`: 2-flop synchroniser, reset value 1, one bit wide.

## Test plan
- **Clean frame:** 8 bits, even parity, OVERSAMPLE=16. Send 0xA5 with parity 0 and stop 1 → `o_data`=9'h0A5, `o_valid`=1, both error flags 0, `o_valid` held until `i_ready`.
- **Parity error:** send 0xA5 with parity 1 → `o_data`=9'h1A5, `o_parity_err`=1, `o_framing_err`=0.
- **Framing error / break:** send 0x3C with stop bit 0, then hold the line low 3 bit periods → `o_framing_err`=1, `o_busy` stays high (BREAK) until the line goes high, then IDLE. Next frame 0x81 is received clean.
- **Glitch:** line low for 4 ticks, then high → no `o_valid`; state returns to IDLE by tick MID.
- **Overrun:** `i_ready`=0, back-to-back frames 0x3C then 0xC3 → one `o_overrun` pulse at the second commit; `o_data` = 0xC3 frame; `o_valid` stays 1.
- **Reset mid-frame:** assert `reset` for 1 `clk` after data bit 3 of 0xFF → all outputs 0, IDLE. A following 0x5A frame yields `o_data`=9'h05A with no errors.
